// File: rtl/mult_datapath.sv
// mult_datapath: nibble-serial 8x8 multiplier datapath steered by mult_control.
// MULT_DP_OUTREG_EN adds a registered valid/ready result port with sticky overrun.
module mult_datapath (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    input  logic [1:0]  input_sel,
    input  logic [1:0]  shift_sel,
    input  logic        clk_ena,
    input  logic        sclr_n,
    input  logic        done,
    input  logic        result_ready,
    output logic [1:0]  count,
    output logic [15:0] product,
    output logic        result_valid,
    output logic        overrun
);
    logic [7:0]  op_a, op_b, pp;
    logic [3:0]  na, nb;
    logic [15:0] acc, shifted;

    always_ff @(posedge clk or negedge reset_a)
        if (!reset_a) begin
            op_a <= '0;
            op_b <= '0;
        end else if (start) begin
            op_a <= dataa;
            op_b <= datab;
        end

    // input_sel[1] picks the high multiplicand nibble, input_sel[0] the high multiplier nibble
    always_comb begin
        na      = input_sel[1] ? op_a[7:4] : op_a[3:0];
        nb      = input_sel[0] ? op_b[7:4] : op_b[3:0];
        pp      = na * nb;
        shifted = shift_sel == 2'b01 ? {4'd0, pp, 4'd0} :
                  shift_sel == 2'b10 ? {pp, 8'd0} : {8'd0, pp};
    end

    always_ff @(posedge clk or negedge reset_a)
        if (!reset_a) begin
            acc   <= '0;
            count <= '0;
        end else if (!sclr_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clk_ena) begin
            acc <= acc + shifted;
            if (count != 2'd3)
                count <= count + 2'd1;
        end

`ifdef MULT_DP_OUTREG_EN
    logic [15:0] res;

    always_ff @(posedge clk or negedge reset_a)
        if (!reset_a) begin
            res          <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (done) begin
            res          <= acc;
            result_valid <= 1'b1;
            if (result_valid && !result_ready)
                overrun <= 1'b1;
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end

    assign product = res;
`else
    logic unused_ready;

    assign unused_ready = result_ready;
    assign product      = acc;
    assign result_valid = done;
    assign overrun      = 1'b0;
`endif
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed + random checks of mult_datapath against an arithmetic reference.
// Follows MULT_DP_OUTREG_EN the same way the design does.
module tb_mult_datapath;
    logic        clk = 0, reset_a = 0, start = 0, clk_ena = 0, sclr_n = 1, done = 0, result_ready = 0;
    logic [7:0]  dataa = 0, datab = 0;
    logic [1:0]  input_sel = 0, shift_sel = 0;
    logic [1:0]  count;
    logic [15:0] product;
    logic        result_valid, overrun;
    int          tests = 0, fails = 0;

    mult_datapath dut (
        .clk(clk), .reset_a(reset_a), .start(start), .dataa(dataa), .datab(datab),
        .input_sel(input_sel), .shift_sel(shift_sel), .clk_ena(clk_ena), .sclr_n(sclr_n),
        .done(done), .result_ready(result_ready), .count(count), .product(product),
        .result_valid(result_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic sc, input logic en, input logic [1:0] is, input logic [1:0] ss);
        start = st; sclr_n = sc; clk_ena = en; done = 0; input_sel = is; shift_sel = ss;
        @(posedge clk); #1;
    endtask

    // full standard sequence; reference is the sum of nibble products weighted by powers of 16
    task automatic mul(input logic [7:0] a, input logic [7:0] b);
        int ai[4], bi[4], wt[4], part;
        logic [15:0] full;
        ai = '{a % 16, a % 16, a / 16, a / 16};
        bi = '{b % 16, b / 16, b % 16, b / 16};
        wt = '{1, 16, 16, 256};
        full = 16'(int'(a) * int'(b));
        part = 0;
        dataa = a; datab = b;
        cyc(1, 0, 0, 2'd0, 2'd0);
        chk("clr_count", {14'd0, count}, 16'd0);
`ifndef MULT_DP_OUTREG_EN
        chk("clr_acc", product, 16'd0);
`endif
        for (int k = 0; k < 4; k++) begin
            part += ai[k] * bi[k] * wt[k];
            cyc(0, 1, 1, 2'(k), k == 0 ? 2'd0 : k == 3 ? 2'd2 : 2'd1);
            chk("step_count", {14'd0, count}, k < 3 ? 16'(k + 1) : 16'd3);
`ifndef MULT_DP_OUTREG_EN
            chk("step_acc", product, 16'(part));
`endif
        end
        start = 0; clk_ena = 0; done = 1; input_sel = 2'($urandom); shift_sel = 2'($urandom);
        #1;
`ifndef MULT_DP_OUTREG_EN
        chk("done_valid", {15'd0, result_valid}, 16'd1);
        chk("done_product", product, full);
`endif
        @(posedge clk); #1;
        done = 0; #1;
        chk("hold_count", {14'd0, count}, 16'd3);
        chk("final_product", product, full);
`ifdef MULT_DP_OUTREG_EN
        chk("reg_valid", {15'd0, result_valid}, 16'd1);
`else
        chk("valid_drop", {15'd0, result_valid}, 16'd0);
`endif
    endtask

    initial begin
        #1;
        chk("rst_product", product, 16'd0);
        chk("rst_count", {14'd0, count}, 16'd0);
        chk("rst_valid", {15'd0, result_valid}, 16'd0);
        #7 reset_a = 1;
        @(posedge clk); #1;
        result_ready = 1;

        mul(8'hFF, 8'hFF);
        mul(8'h12, 8'h34);

        // async reset after the second enabled step
        dataa = 8'hA7; datab = 8'h5C;
        cyc(1, 0, 0, 2'd0, 2'd0);
        cyc(0, 1, 1, 2'd0, 2'd0);
        cyc(0, 1, 1, 2'd1, 2'd1);
        reset_a = 0; #1;
        chk("arst_count", {14'd0, count}, 16'd0);
        chk("arst_product", product, 16'd0);
        chk("arst_valid", {15'd0, result_valid}, 16'd0);
        #1 reset_a = 1;
        mul(8'h0F, 8'h0F);

        // clear beats enable; disabled cycles ignore the selects
        mul(8'h9B, 8'h6D);
        cyc(0, 0, 1, 2'd3, 2'd0);
        chk("clr_en_count", {14'd0, count}, 16'd0);
`ifndef MULT_DP_OUTREG_EN
        chk("clr_en_acc", product, 16'd0);
`endif
        cyc(0, 1, 1, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 2'($urandom), 2'($urandom));
            chk("hold_dis_count", {14'd0, count}, 16'd1);
`ifndef MULT_DP_OUTREG_EN
            chk("hold_dis_acc", product, 16'h0B * 16'h0D);
`endif
        end

        for (int i = 0; i < 20; i++)
            mul(8'($urandom), 8'($urandom));

`ifdef MULT_DP_OUTREG_EN
        chk("no_overrun_yet", {15'd0, overrun}, 16'd0);
        result_ready = 0;
        mul(8'd3, 8'd5);
        mul(8'd7, 8'd9);
        chk("bp_product", product, 16'h003F);
        chk("bp_valid", {15'd0, result_valid}, 16'd1);
        chk("bp_overrun", {15'd0, overrun}, 16'd1);
        result_ready = 1;
        cyc(0, 1, 0, 2'd0, 2'd0);
        result_ready = 0;
        chk("bp_drain_valid", {15'd0, result_valid}, 16'd0);
        chk("bp_sticky", {15'd0, overrun}, 16'd1);
        reset_a = 0; #1;
        chk("bp_rst_overrun", {15'd0, overrun}, 16'd0);
        chk("bp_rst_product", product, 16'd0);
        #1 reset_a = 1;
`else
        chk("overrun_tied", {15'd0, overrun}, 16'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
